// File: rtl/serial_adder_if.sv
// Start/busy/done bus for the bit-serial adder. Build with SERIAL_ADDER_SUB_EN
// defined to add the sub request bit.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    // Handshake: start is honoured only while busy is low (IDLE or the DONE
    // cycle); done is a one-cycle pulse and sum/cout are valid in that cycle.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage, LSB first, WIDTH clocks per result.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus,
    output logic [1:0]           state_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             accept;

    assign s_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);

    // Result register fills from the top so the last bit lands in the MSB.
    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_d = s_bit;
        end else begin : g_r_wn
            assign r_d = {s_bit, r_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADDER_SUB_EN
    // a - b as a + ~b + 1; carry-out high means no borrow.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    r_q     <= r_d;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= c_bit;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= r_d;
                        cout_q  <= c_bit;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign state_o  = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] state8;
    logic [1:0] state1;
    int         cyc;
    int         checks;
    int         errors;

    logic [W:0] exp_q[$];
    int         lat_q[$];

    serial_adder_if #(.WIDTH(W)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .state_o(state8)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_o(state1)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: pop expectations whenever the main DUT pulses done
    always @(negedge clk) begin
        if (rst_n && bus8.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                int         l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("result", {23'd0, bus8.cout, bus8.sum}, {23'd0, e});
                check("latency", cyc, l);
            end
        end
    end

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic ts, input logic push, input logic [W:0] exp);
        bus8.a     = ta;
        bus8.b     = tb_v;
        bus8.cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = ts;
`else
        if (ts) $display("note: sub requested in add-only build");
`endif
        bus8.start = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(cyc + 1 + W);
        end
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic ts, input logic [W:0] exp);
        @(negedge clk);
        drive(ta, tb_v, tc, ts, 1'b1, exp);
        @(negedge clk);
        bus8.start = 1'b0;
        check("busy_after_start", {31'd0, bus8.busy}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check(name, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst_n = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b0; bus1.sub = 1'b0;
`endif
        // asynchronous reset, checked mid-cycle before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_sum",  {24'd0, bus8.sum},  32'h00);
        check("rst_cout", {31'd0, bus8.cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic add and carry cases
        issue(8'h35, 8'h4A, 1'b0, 1'b0, 9'h07F);
        drain("timeout_basic");
        repeat (3) @(negedge clk);
        check("sum_held", {23'd0, bus8.cout, bus8.sum}, 32'h07F);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        drain("timeout_carry1");
        issue(8'h00, 8'h00, 1'b1, 1'b0, 9'h001);
        drain("timeout_cin");
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
        drain("timeout_max");

        // start during RUN is ignored
        issue(8'h12, 8'h34, 1'b0, 1'b0, 9'h046);
        repeat (2) @(negedge clk);
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        bus8.start = 1'b0;
        check("sum_held_in_run", {23'd0, bus8.cout, bus8.sum}, 32'h1FF);
        drain("timeout_ignored");

        // back-to-back: restart in the DONE cycle
        @(negedge clk);
        drive(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 9'h030);
        @(negedge clk);
        bus8.start = 1'b0;
        begin
            int n;
            n = 0;
            while (bus8.done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) check("timeout_b2b", 32'd1, 32'd0);
        end
        drive(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, 9'h007);
        @(negedge clk);
        bus8.start = 1'b0;
        drain("timeout_b2b2");

        // reset in the middle of RUN aborts the operation
        @(negedge clk);
        drive(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 9'h000);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus8.busy}, 32'd0);
        check("midrst_sum",  {23'd0, bus8.cout, bus8.sum}, 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        issue(8'h01, 8'h02, 1'b0, 1'b0, 9'h003);
        drain("timeout_after_rst");

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h10, 8'h20, 1'b0, 1'b1, 9'h0F0);
        drain("timeout_sub1");
        issue(8'h20, 8'h10, 1'b0, 1'b1, 9'h110);
        drain("timeout_sub2");
        issue(8'h20, 8'h10, 1'b1, 1'b1, 9'h110);
        drain("timeout_sub_cin");
        issue(8'h20, 8'h10, 1'b1, 1'b0, 9'h031);
        drain("timeout_add_after_sub");
`endif

        // WIDTH=1 instance: 1 + 1 -> sum 0, cout 1, done one cycle after start
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b0; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("w1_busy", {30'd0, bus1.busy, bus1.done}, 32'b10);
        @(negedge clk);
        check("w1_done", {30'd0, bus1.busy, bus1.done}, 32'b01);
        check("w1_result", {30'd0, bus1.cout, bus1.sum}, 32'b10);
        @(negedge clk);
        check("w1_done_pulse", {31'd0, bus1.done}, 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock through a single registered full-adder stage.
- Start/busy/done handshake.
- Used where area matters more than latency, and as the first sequential exercise in the adder lab series.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result; updated only at completion, held otherwise
cout  output  1  carry-out of MSB; updated only at completion

Behaviour:
- Reset (rst_n low, async, any state):
  - state = IDLE; busy = 0; done = 0; sum = 0; cout = 0.
  - Internal shift registers, carry register and bit counter cleared.
  - Deassertion is synchronous to clk, first edge after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge E0 loads a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0; goes to RUN.
  - busy = 1 from E0.
- RUN, each edge:
  - Full-add of a_sh[0], b_sh[0], carry.
  - Sum bit shifts into MSB of the internal result register r_sh.
  - a_sh and b_sh shift right by 1; carry <= carry-out of the stage; cnt <= cnt + 1.
  - start is ignored; operands a, b, cin may change freely without effect.
- Completion, edge E0+WIDTH (cnt reaches WIDTH-1 before this edge):
  - Final bit processed.
  - sum <= completed result (r_sh including this last bit); cout <= final carry.
  - state -> DONE; busy = 0; done = 1.
- DONE (exactly one cycle):
  - start = 1 begins a new operation immediately, identical to IDLE acceptance (back-to-back throughput: one result per WIDTH+1 cycles).
  - Otherwise returns to IDLE; done = 0.
- Latency: done observed WIDTH cycles after the start edge; sum/cout valid in the same cycle as done.
- Hold rules:
  - sum/cout keep the previous result throughout RUN and IDLE.
  - They never show partial results.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1), exact.
- Counter width: $clog2(WIDTH+1); no wrap occurs within an operation.
- WIDTH = 1: RUN lasts one edge; done one cycle after start.
- Reset mid-RUN: operation aborted; done never pulses; sum/cout return to 0.

Optional Feature:
Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with start.
  - sub = 1 computes a - b: b_sh loaded with ~b, carry loaded with 1, cin ignored.
  - cout = 1 means no borrow (a >= b unsigned).
  - sub = 0 behaves exactly as the base adder.
- Not defined:
  - Port sub does not exist.
  - Block is add-only, as described above.

Test Plan:
- Reset values: assert rst_n = 0 mid-cycle → busy = 0, done = 0, sum = 8'h00, cout = 0 immediately (asynchronous).
- Basic add, WIDTH = 8: a = 8'h35, b = 8'h4A, cin = 0, start 1 cycle → busy for 8 cycles, done pulse at edge E0+8, sum = 8'h7F, cout = 0; sum held afterwards.
- Carry cases:
  - a = 8'hFF, b = 8'h01, cin = 0 → sum = 8'h00, cout = 1.
  - a = 8'h00, b = 8'h00, cin = 1 → sum = 8'h01, cout = 0.
  - a = 8'hFF, b = 8'hFF, cin = 1 → sum = 8'hFF, cout = 1.
- Protocol:
  - start pulsed again at cycle 3 of RUN with different operands → ignored, first result unchanged.
  - start held high in DONE → second operation starts with no IDLE gap; second done 9 cycles after first.
- Reset mid-operation: rst_n low at cycle 4 of RUN, then release and start a = 8'h01, b = 8'h02 → no stale done; sum = 8'h03, cout = 0.
- SERIAL_ADDER_SUB_EN build:
  - sub = 1, a = 8'h10, b = 8'h20 → sum = 8'hF0, cout = 0.
  - sub = 1, a = 8'h20, b = 8'h10 → sum = 8'h10, cout = 1.
  - WIDTH = 1 build: 1 + 1 → sum = 0, cout = 1, done one cycle after start.
